// File: rtl/params.sv
// Shared RV32I definitions used by the decode stage and the ALU.
// Holds the datapath width, ALU op encoding, opcode/funct7 constants
// and the decoded-instruction record handed from decode to execute.
package params;

  localparam int WORD_SIZE = 32;

  // ALU op encoding shared with the ALU; ADD is zero so a cleared record decodes as ADD.
  typedef enum logic [3:0] {
    OP_ALU_ADD  = 4'd0,
    OP_ALU_SUB  = 4'd1,
    OP_ALU_SLL  = 4'd2,
    OP_ALU_SLT  = 4'd3,
    OP_ALU_SLTU = 4'd4,
    OP_ALU_XOR  = 4'd5,
    OP_ALU_SRL  = 4'd6,
    OP_ALU_SRA  = 4'd7,
    OP_ALU_OR   = 4'd8,
    OP_ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e               alu_op;
    logic [WORD_SIZE-1:0]  a;
    logic [WORD_SIZE-1:0]  b;
    logic [4:0]            rd;
    logic                  wb_en;
    logic                  illegal;
  } decoded_t;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_ALU_SLL) || (op == OP_ALU_SRL) || (op == OP_ALU_SRA);
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purpose: combinational RV32I ALU-class decoder (OP, OP-IMM, LUI, AUIPC).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the wrapping stage owns the handshake.
// Ports: instr/pc/rs1_data/rs2_data in; rs1_addr/rs2_addr and a decoded_t record out.
module decode_comb
  import params::*;
(
  input  logic [31:0]          instr,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] rs1_data,
  input  logic [WORD_SIZE-1:0] rs2_data,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  output decoded_t             dec
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [WORD_SIZE-1:0] imm_i;
  logic [WORD_SIZE-1:0] imm_u;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  alu_op_e              op;
  logic                 legal;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign imm_i    = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
  assign imm_u    = {instr[31:12], 12'b0};

  always_comb begin
    op    = OP_ALU_ADD;
    op_a  = '0;
    op_b  = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        op_a = rs1_data;
        op_b = rs2_data;
        if (funct7 == FUNCT7_BASE) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  op = OP_ALU_ADD;
            3'b001:  op = OP_ALU_SLL;
            3'b010:  op = OP_ALU_SLT;
            3'b011:  op = OP_ALU_SLTU;
            3'b100:  op = OP_ALU_XOR;
            3'b101:  op = OP_ALU_SRL;
            3'b110:  op = OP_ALU_OR;
            default: op = OP_ALU_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000) begin
            op    = OP_ALU_SUB;
            legal = 1'b1;
          end else if (funct3 == 3'b101) begin
            op    = OP_ALU_SRA;
            legal = 1'b1;
          end
        end
      end
      OPC_OP_IMM: begin
        op_a = rs1_data;
        // SLTIU also uses the sign-extended immediate; the ALU compares it unsigned.
        op_b = imm_i;
        case (funct3)
          3'b000: begin op = OP_ALU_ADD;  legal = 1'b1; end
          3'b001: begin op = OP_ALU_SLL;  legal = (funct7 == FUNCT7_BASE); end
          3'b010: begin op = OP_ALU_SLT;  legal = 1'b1; end
          3'b011: begin op = OP_ALU_SLTU; legal = 1'b1; end
          3'b100: begin op = OP_ALU_XOR;  legal = 1'b1; end
          3'b101: begin
            op    = (funct7 == FUNCT7_ALT) ? OP_ALU_SRA : OP_ALU_SRL;
            legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          end
          3'b110: begin op = OP_ALU_OR;   legal = 1'b1; end
          default: begin op = OP_ALU_AND; legal = 1'b1; end
        endcase
      end
      OPC_LUI: begin
        op_b  = imm_u;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        op_a  = pc;
        op_b  = imm_u;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // The ALU shifts by the whole of operand b, so the shift amount is masked here.
    if (is_shift(op)) begin
      op_b = {{(WORD_SIZE-5){1'b0}}, op_b[4:0]};
    end

    // Illegal encodings still flow downstream as a clean ADD 0,0 so execute can trap.
    if (!legal) begin
      op   = OP_ALU_ADD;
      op_a = '0;
      op_b = '0;
    end

    dec.alu_op  = op;
    dec.a       = op_a;
    dec.b       = op_b;
    dec.rd      = instr[11:7];
    dec.wb_en   = legal && (instr[11:7] != 5'd0);
    dec.illegal = !legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Purpose: RV32I decode stage feeding the ALU, one-entry output register plus legal-handoff counter.
// Latency: 1 cycle from accept to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready = !flush && (!out_valid || out_ready); held entry is stable while stalled.
// Ports: in_* fetch handshake, rf_* register file read, out_* execute handshake, flush, decoded_count.
module decode_stage
  import params::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [WORD_SIZE-1:0] in_pc,
  output logic [4:0]           rf_rs1_addr,
  output logic [4:0]           rf_rs2_addr,
  input  logic [WORD_SIZE-1:0] rf_rs1_data,
  input  logic [WORD_SIZE-1:0] rf_rs2_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output alu_op_e              out_alu_op,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic [4:0]           out_rd,
  output logic                 out_wb_en,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] decoded_count
);

  decoded_t             dec_comb;
  decoded_t             dec_d, dec_q;
  logic                 valid_d, valid_q;
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 accept;
  logic                 handoff;

  decode_comb u_decode_comb (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .rs1_addr (rf_rs1_addr),
    .rs2_addr (rf_rs2_addr),
    .dec      (dec_comb)
  );

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed entry is killed, not handed off, even if execute was ready.
  assign handoff  = valid_q && out_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    count_d = count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec_comb;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (handoff && !dec_q.illegal) begin
      count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= 1'b0;
      dec_q          <= '0;
      dec_q.alu_op   <= OP_ALU_ADD;
      count_q        <= '0;
    end else begin
      valid_q        <= valid_d;
      dec_q          <= dec_d;
      count_q        <= count_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_alu_op    = dec_q.alu_op;
  assign out_a         = dec_q.a;
  assign out_b         = dec_q.b;
  assign out_rd        = dec_q.rd;
  assign out_wb_en     = dec_q.wb_en;
  assign out_illegal   = dec_q.illegal;
  assign decoded_count = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose: scoreboard bench for decode_stage with directed RV32I vectors.
// Latency: expects each accepted instruction at the output one cycle later.
// Backpressure: exercises out_ready stalls, flush and asynchronous reset.
module tb_decode_stage;
  import params::*;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic [4:0]    rf_rs1_addr;
  logic [4:0]    rf_rs2_addr;
  logic [31:0]   rf_rs1_data;
  logic [31:0]   rf_rs2_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  alu_op_e       out_alu_op;
  logic [31:0]   out_a;
  logic [31:0]   out_b;
  logic [4:0]    out_rd;
  logic          out_wb_en;
  logic          out_illegal;
  logic [31:0]   decoded_count;

  decode_stage #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_illegal(out_illegal), .decoded_count(decoded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  int       exp_count = 0;
  decoded_t exp_q[$];
  decoded_t act;

  assign act = {out_alu_op, out_a, out_b, out_rd, out_wb_en, out_illegal};

  function automatic decoded_t mk(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic wb, input logic ill);
    decoded_t d;
    d.alu_op = op; d.a = a; d.b = b; d.rd = rd; d.wb_en = wb; d.illegal = ill;
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every handoff pops the oldest expected record.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h expected none", act);
      end else begin
        decoded_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL out_record got %h expected %h", act, e);
        end
        if (!e.illegal) exp_count++;
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting posedge with in_valid low.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input decoded_t e, input bit push);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; rf_rs1_data = r1; rf_rs2_data = r2;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout got in_ready=0 expected accept for %h", instr);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    decoded_t snap;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_rs1_data = '0; rf_rs2_data = '0; flush = 1'b0; out_ready = 1'b1;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", out_alu_op, OP_ALU_ADD);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_rd_wb_ill", {out_rd, out_wb_en, out_illegal}, 0);
    chk("rst_count", decoded_count, 0);
    chk("rst_in_ready", in_ready, 1);
    #10 rst = 1'b0;
    idle(1);

    // Directed decode vectors, execute always ready.
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(OP_ALU_ADD, 32'd5, 32'd7, 5'd3, 1, 0), 1);
    chk("rs_addr_add", {rf_rs1_addr, rf_rs2_addr}, {5'd1, 5'd2});
    send(32'h40435293, 32'h0, 32'hFFFF_FF00, 32'h0,
         mk(OP_ALU_SRA, 32'hFFFF_FF00, 32'd4, 5'd5, 1, 0), 1);
    send(32'h40431293, 32'h0, 32'hFFFF_FF00, 32'h0, mk(OP_ALU_ADD, 0, 0, 5'd5, 0, 1), 1);
    send(32'h12345097, 32'h100, 32'h0, 32'h0,
         mk(OP_ALU_ADD, 32'h100, 32'h1234_5000, 5'd1, 1, 0), 1);
    send(32'hFFF00013, 32'h0, 32'h0, 32'h0, mk(OP_ALU_ADD, 0, 32'hFFFF_FFFF, 5'd0, 0, 0), 1);
    send(32'hABCDE137, 32'h0, 32'h55, 32'h66, mk(OP_ALU_ADD, 0, 32'hABCD_E000, 5'd2, 1, 0), 1);
    send(32'h00209233, 32'h0, 32'd9, 32'h23, mk(OP_ALU_SLL, 32'd9, 32'd3, 5'd4, 1, 0), 1);
    send(32'h402082B3, 32'h0, 32'd10, 32'd3, mk(OP_ALU_SUB, 32'd10, 32'd3, 5'd5, 1, 0), 1);
    send(32'h0000037F, 32'h0, 32'd1, 32'd1, mk(OP_ALU_ADD, 0, 0, 5'd6, 0, 1), 1);
    send(32'hFFF0B393, 32'h0, 32'd1, 32'h0,
         mk(OP_ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd7, 1, 0), 1);
    idle(3);
    chk("count_directed", decoded_count, 8);
    chk("count_model", decoded_count, exp_count);
    chk("drained_valid", out_valid, 0);

    // Back-to-back ADDI stream with a two-cycle execute stall.
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          logic [31:0] ins;
          ins = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
          send(ins, 32'h0, 32'h10 * k, 32'h0,
               mk(OP_ALU_ADD, 32'h10 * k, 32'(k), 5'(k), 1, 0), 1);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        snap = act;
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready_a", in_ready, 0);
        @(negedge clk);
        chk("stall_in_ready_b", in_ready, 0);
        chk("stall_hold", act, snap);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);
    chk("count_stream", decoded_count, 12);
    chk("stream_queue_empty", exp_q.size(), 0);

    // Flush while a legal entry is held and another instruction is offered.
    out_ready = 1'b0;
    send(32'h00100093, 32'h0, 32'h0, 32'h0, mk(OP_ALU_ADD, 0, 1, 5'd1, 1, 0), 0);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00200113;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_held_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("flush_kills", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    idle(2);
    chk("flush_not_counted", decoded_count, 12);
    chk("flush_nothing_loaded", out_valid, 0);

    // Asynchronous reset between edges with an entry held.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(OP_ALU_ADD, 5, 7, 5'd3, 1, 0), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", decoded_count, 0);
    chk("arst_rd_a", {out_rd, out_a}, 0);
    exp_count = 0;
    idle(1);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(OP_ALU_ADD, 5, 7, 5'd3, 1, 0), 1);
    idle(3);
    chk("post_rst_count", decoded_count, 1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage directly upstream of the ALU.
- Accepts fetched instructions over a valid/ready handshake and reads source operands from the register file.
- Decodes the ALU-class instructions (OP, OP-IMM, LUI, AUIPC) and registers the ALU op code, both operands, destination and writeback controls for the execute stage.
- One-entry pipeline register with stall, flush and a retired-decode counter.

Parameters:
- WORD_SIZE, 32 (from shared package), datapath width.
- CNT_WIDTH, 32, width of decoded-instruction counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- in_pc  input  WORD_SIZE  instruction address
- rf_rs1_addr  output  5  combinational from in_instr[19:15]
- rf_rs2_addr  output  5  combinational from in_instr[24:20]
- rf_rs1_data  input  WORD_SIZE  register file read data, same cycle
- rf_rs2_data  input  WORD_SIZE  register file read data, same cycle
- flush  input  1  kill held entry and block acceptance this cycle
- out_valid  output  1  registered entry is valid
- out_ready  input  1  execute stage consumes entry
- out_alu_op  output  alu_op  ALU op code
- out_a  output  WORD_SIZE  ALU operand a
- out_b  output  WORD_SIZE  ALU operand b
- out_rd  output  5  destination register
- out_wb_en  output  1  write result to rd
- out_illegal  output  1  instruction not decodable
- decoded_count  output  CNT_WIDTH  count of legal instructions handed off

Behaviour:
- Reset (async, rst=1): all outputs are registered and clear.
  - out_valid=0, out_alu_op=OP_ALU_ADD, out_a=out_b=0.
  - out_rd=0, out_wb_en=0, out_illegal=0, decoded_count=0.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - Accept when in_valid && in_ready. The output register loads on the next clk edge; latency is 1 cycle.
  - Accept with out_valid && out_ready in the same cycle: the old entry leaves and the new one loads. No bubble, full throughput.
  - out_valid=1 && !out_ready: all out_* hold stable and in_ready=0.
- Flush has priority over everything. The next edge sets out_valid=0 and nothing is accepted, even when in_valid=1.
- decoded_count increments on out_valid && out_ready && !out_illegal && !flush, and wraps modulo 2^CNT_WIDTH.
- Decode (on in_instr):
  - OP (0110011), operands a=rs1_data, b=rs2_data.
    - funct7=0000000: funct3 maps 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000: funct3 000 SUB, 101 SRA.
    - Any other funct7/funct3 pairing is illegal.
  - OP-IMM (0010011), operands a=rs1_data, b=sign-extended imm[31:20].
    - funct3 maps as for OP, with no SUB.
    - 001 (SLLI) requires funct7=0000000.
    - 101 requires funct7 0000000 (SRLI) or 0100000 (SRAI).
  - Shift amounts: for every shift op, out_b = {27'b0, amount[4:0]}. The ALU shifts by full operand b, so masking happens here.
  - LUI (0110111): ADD, a=0, b={instr[31:12],12'b0}.
  - AUIPC (0010111): ADD, a=in_pc, b={instr[31:12],12'b0}.
  - Any other opcode, or an illegal funct pairing:
    - out_illegal=1, out_alu_op=OP_ALU_ADD, out_a=out_b=0, out_wb_en=0.
    - The entry still passes through the handshake so execute can trap.
- out_rd = instr[11:7]. out_wb_en = legal && rd!=0.
- SLTIU compares against the sign-extended immediate, interpreted unsigned.
- rf_rs*_addr are driven even for non-reading opcodes; the data is then ignored.
- No forwarding or hazard detection; these are owned by a separate block.

Decomposition:
- Shared package (params.sv) holds:
  - WORD_SIZE and the alu_op enum, as already used by the ALU.
  - New opcode constants: OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - FUNCT7_BASE / FUNCT7_ALT constants.
  - A decoded_t struct {alu_op, a, b, rd, wb_en, illegal}.
- Natural sub-module: decode_comb. It is purely combinational, maps instr/pc/rs data to decoded_t, and is unit-testable alone. decode_stage wraps it with the handshake register and the counter.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ADD, a=5, b=7, rd=3, wb_en=1; decoded_count=1 after handoff.
- SRAI x5,x6,4 (0x40435293), rs1=0xFFFF_FF00 -> SRA, b=4. SLLI with funct7=0100000 (0x40431293) -> illegal=1, wb_en=0, count unchanged.
- AUIPC x1,0x12345 at pc=0x100 -> ADD, a=0x100, b=0x1234_5000. ADDI x0,x0,-1 -> b=0xFFFF_FFFF, wb_en=0.
- Back-to-back stream of 4 ADDIs with out_ready low for 2 cycles mid-stream:
  - in_ready=0 and out_* stable while stalled.
  - All 4 delivered in order, none lost or duplicated.
- flush=1 while out_valid=1 and in_valid=1 -> in_ready=0, out_valid=0 next cycle, flushed entry not counted.
- Assert rst mid-stream asynchronously (between edges) -> out_valid and decoded_count clear immediately; the first accept after release behaves as from power-up.
